// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: control-FSM state encoding and
// destination address constants.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0 = 2'd0;
    localparam logic [1:0] ADDR1 = 2'd1;
    localparam logic [1:0] ADDR2 = 2'd2;

endpackage

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: decodes the header address, sequences
// header/payload/parity writes into the selected FIFO and stalls on full/busy.
module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic       parity_done,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       fifo_full,
    input  logic       low_pkt_valid,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic [1:0] data_in,
    output logic       busy,
    output logic       lfd_state,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr;
    logic       soft_hit;
    logic       addr_empty;

    // A timeout soft reset only matters for the FIFO this packet is routed to.
    assign soft_hit = (addr == ADDR0 && soft_reset_0) ||
                      (addr == ADDR1 && soft_reset_1) ||
                      (addr == ADDR2 && soft_reset_2);

    assign addr_empty = (addr == ADDR0 && fifo_empty_0) ||
                        (addr == ADDR1 && fifo_empty_1) ||
                        (addr == ADDR2 && fifo_empty_2);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= DECODE_ADDRESS;
            addr  <= ADDR0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr <= data_in;
        end
    end

    always_comb begin
        // NOTE: defaulting next_state to the current state before the case
        // keeps every path assigned, so no latch is inferred.
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if ((data_in == ADDR0 && fifo_empty_0) ||
                        (data_in == ADDR1 && fifo_empty_1) ||
                        (data_in == ADDR2 && fifo_empty_2))
                        next_state = LOAD_FIRST_DATA;
                    else if (data_in == ADDR0 || data_in == ADDR1 || data_in == ADDR2)
                        next_state = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else
                    next_state = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (addr_empty)
                    next_state = LOAD_FIRST_DATA;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        if (soft_hit)
            next_state = DECODE_ADDRESS;
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus pushes the expected output vector
// for each edge, a monitor pops and compares one cycle-sample at a time.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, parity_done, fifo_full, low_pkt_valid;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [1:0] data_in;
    logic       busy, lfd_state, detect_add, ld_state, laf_state;
    logic       full_state, write_enb_reg, rst_int_reg;

    // Output vector: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
    localparam logic [7:0] E_DA   = 8'b0100_0000;
    localparam logic [7:0] E_LFD  = 8'b1010_0000;
    localparam logic [7:0] E_LD   = 8'b0001_0010;
    localparam logic [7:0] E_WTE  = 8'b1000_0000;
    localparam logic [7:0] E_FULL = 8'b1000_0100;
    localparam logic [7:0] E_LAF  = 8'b1000_1010;
    localparam logic [7:0] E_LP   = 8'b1000_0010;
    localparam logic [7:0] E_CPE  = 8'b1000_0001;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks   = 0;
    int         failures = 0;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .parity_done   (parity_done),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .fifo_full     (fifo_full),
        .low_pkt_valid (low_pkt_valid),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .data_in       (data_in),
        .busy          (busy),
        .lfd_state     (lfd_state),
        .detect_add    (detect_add),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg)
    );

    always #5 clock = ~clock;

    task automatic clr();
        resetn = 0; pkt_valid = 0; parity_done = 0; fifo_full = 0; low_pkt_valid = 0;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        fifo_empty_0 = 0; fifo_empty_1 = 0; fifo_empty_2 = 0; data_in = 2'd0;
    endtask

    // Queue the outputs expected after the coming edge, then let the edge happen.
    task automatic step(input logic [7:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clock);
        #2;
    endtask

    initial begin : monitor
        logic [7:0] act, e;
        string      n;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                act = {busy, detect_add, lfd_state, ld_state, laf_state,
                       full_state, write_enb_reg, rst_int_reg};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: outputs=%b expected=%b", n, act, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        clr();
        @(negedge clock);
        resetn = 1;                                        step(E_DA,   "reset");
        resetn = 0;                                        step(E_DA,   "idle_1");
        step(E_DA, "idle_2");

        // Normal path, address 1
        pkt_valid = 1; data_in = 2'd1; fifo_empty_1 = 1;   step(E_LFD,  "a1_lfd");
        step(E_LD, "a1_ld");
        fifo_full = 1;                                     step(E_FULL, "a1_full");
        fifo_full = 0;                                     step(E_LAF,  "a1_laf");
        low_pkt_valid = 1;                                 step(E_LP,   "a1_laf_to_lp");
        low_pkt_valid = 0; pkt_valid = 0;                  step(E_CPE,  "a1_cpe");
        step(E_DA, "a1_done");

        // Address 0: LAF back to LD, then CPE into full, LAF with parity_done
        clr(); pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 1;
        step(E_LFD, "a0_lfd");
        step(E_LD, "a0_ld");
        fifo_full = 1;                                     step(E_FULL, "a0_full");
        step(E_FULL, "a0_full_hold");
        fifo_full = 0;                                     step(E_LAF,  "a0_laf");
        step(E_LD, "a0_laf_to_ld");
        step(E_LD, "a0_ld_hold");
        pkt_valid = 0;                                     step(E_LP,   "a0_lp");
        fifo_full = 1;                                     step(E_CPE,  "a0_cpe");
        step(E_FULL, "a0_cpe_to_full");
        fifo_full = 0;                                     step(E_LAF,  "a0_laf2");
        parity_done = 1;                                   step(E_DA,   "a0_laf_parity_done");

        // Address 3 is not a destination
        clr(); pkt_valid = 1; data_in = 2'd3;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        step(E_DA, "addr3_ignored");

        // Busy destination 1; WAIT follows the latched address, not data_in
        clr(); pkt_valid = 1; data_in = 2'd1; fifo_empty_0 = 1;
        step(E_WTE, "a1_wait");
        data_in = 2'd0;                                    step(E_WTE,  "a1_wait_hold1");
        step(E_WTE, "a1_wait_hold2");
        fifo_empty_1 = 1;                                  step(E_LFD,  "a1_wait_to_lfd");
        step(E_LD, "a1b_ld");
        pkt_valid = 0; fifo_full = 1;                      step(E_FULL, "ld_full_priority");

        // Soft reset with address 1 latched
        soft_reset_0 = 1; soft_reset_2 = 1;                step(E_FULL, "soft_other_ignored");
        soft_reset_0 = 0; soft_reset_2 = 0; soft_reset_1 = 1;
        step(E_DA, "soft_reset_1");

        // Soft reset with address 0 latched, in FIFO_FULL_STATE
        clr(); pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 1;
        step(E_LFD, "s0_lfd");
        step(E_LD, "s0_ld");
        fifo_full = 1;                                     step(E_FULL, "s0_full");
        soft_reset_1 = 1;                                  step(E_FULL, "s0_soft1_ignored");
        soft_reset_1 = 0; soft_reset_0 = 1;                step(E_DA,   "s0_soft0");

        // Address 2: soft reset out of WAIT, then sync reset out of LFD
        clr(); pkt_valid = 1; data_in = 2'd2;
        step(E_WTE, "a2_wait");
        soft_reset_2 = 1;                                  step(E_DA,   "a2_soft_wait");
        soft_reset_2 = 0; fifo_empty_2 = 1;                step(E_LFD,  "a2_lfd");
        resetn = 1;                                        step(E_DA,   "reset_mid_packet");
        resetn = 0; pkt_valid = 0;                         step(E_DA,   "post_reset_idle");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected samples never compared, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
